// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler: gamemode encodings, play-field
// bounds, slot field widths and the LFSR step function.
package obstacle_scheduler_pkg;

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_PLAY  = 2'b01,
    GM_PAUSE = 2'b10,
    GM_END   = 2'b11
  } gamemode_e;

  localparam int PLAY_UPPER = 120;
  localparam int PLAY_LOWER = 360;

  // Slot k on the x bus is {x_right, x_left}, on the y bus {y_bottom, y_top};
  // an empty slot has every field at zero.
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int X_SLOT_W = 2 * X_W;
  localparam int Y_SLOT_W = 2 * Y_W;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR used for obstacle heights and placement; only the low
// OUT_W bits are exported.
module obstacle_lfsr
  import obstacle_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             clr_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (clr_i) begin
      state_q <= SEED;
    end else if (step_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign rnd_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawns, scrolls and retires obstacles on the scroll tick, and owns the scroll
// speed ramp and the score; the game mode sequences run / freeze / clear.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int          NUM_OBS     = 10,
  parameter int          SCREEN_W    = 640,
  parameter int          OBS_W       = 40,
  parameter int          UPPER_BOUND = PLAY_UPPER,
  parameter int          LOWER_BOUND = PLAY_LOWER,
  parameter int          MIN_H       = 40,
  parameter int          H_BITS      = 6,
  parameter int          SCROLL_DIV  = 250000,
  parameter int          SPAWN_GAP   = 160,
  parameter int          INIT_SPEED  = 2,
  parameter int          MAX_SPEED   = 8,
  parameter int          RAMP_SPAWNS = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   gamemode,
  output logic [X_SLOT_W*NUM_OBS-1:0]  obstacle_x,
  output logic [Y_SLOT_W*NUM_OBS-1:0]  obstacle_y,
  output logic [3:0]                   speed,
  output logic [15:0]                  score
);

  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int CNT_W = $clog2(NUM_OBS + 1);
  localparam int RC_W  = $clog2(RAMP_SPAWNS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCROLL_DIV - 1);
  localparam logic [X_W-1:0]   SPAWN_XL   = X_W'(SCREEN_W - OBS_W);
  localparam logic [X_W-1:0]   SPAWN_XR   = X_W'(SCREEN_W - 1);
  localparam logic [X_W-1:0]   GAP        = X_W'(SPAWN_GAP);
  localparam logic [Y_W-1:0]   Y_UP       = Y_W'(UPPER_BOUND);
  localparam logic [Y_W-1:0]   Y_LO       = Y_W'(LOWER_BOUND);
  localparam logic [Y_W-1:0]   Y_MINH     = Y_W'(MIN_H);
  localparam logic [3:0]       SPEED_INIT = 4'(INIT_SPEED);
  localparam logic [3:0]       SPEED_MAX  = 4'(MAX_SPEED);
  localparam logic [RC_W-1:0]  RAMP_LAST  = RC_W'(RAMP_SPAWNS - 1);

  gamemode_e gm;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [X_W-1:0]     dist_q, dist_d, dist_sum;
  logic [3:0]         speed_q, speed_d;
  logic [15:0]        score_q, score_d;
  logic [RC_W-1:0]    ramp_q, ramp_d;
  logic [NUM_OBS-1:0] valid_q, valid_d;
  logic [X_W-1:0]     xl_q [NUM_OBS];
  logic [X_W-1:0]     xl_d [NUM_OBS];
  logic [X_W-1:0]     xr_q [NUM_OBS];
  logic [X_W-1:0]     xr_d [NUM_OBS];
  logic [Y_W-1:0]     yt_q [NUM_OBS];
  logic [Y_W-1:0]     yt_d [NUM_OBS];
  logic [Y_W-1:0]     yb_q [NUM_OBS];
  logic [Y_W-1:0]     yb_d [NUM_OBS];

  logic               tick, free_found, spawn_go;
  logic [IDX_W-1:0]   free_idx;
  logic [CNT_W-1:0]   n_freed;
  logic [16:0]        score_sum;
  logic [X_W-1:0]     spd_x;
  logic [H_BITS:0]    rnd;
  logic [Y_W-1:0]     h, spawn_top, spawn_bot;

  assign gm   = gamemode_e'(gamemode);
  assign tick = (gm == GM_PLAY) && (div_q == DIV_LAST);

  // The LFSR is never cleared by the init mode so each round gets new shapes.
  obstacle_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (H_BITS + 1)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (tick),
    .clr_i  (1'b0),
    .rnd_o  (rnd)
  );

  assign h         = Y_MINH + Y_W'(rnd[H_BITS:1]);
  assign spawn_top = rnd[0] ? (Y_LO - h) : Y_UP;
  assign spawn_bot = rnd[0] ? Y_LO : (Y_UP + h);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_OBS - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    spd_x     = X_W'(speed_q);
    dist_sum  = dist_q + spd_x;
    spawn_go  = tick && free_found && (dist_sum >= GAP);
    div_d     = div_q;
    dist_d    = dist_q;
    speed_d   = speed_q;
    score_d   = score_q;
    ramp_d    = ramp_q;
    valid_d   = valid_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    yt_d      = yt_q;
    yb_d      = yb_q;
    n_freed   = '0;
    score_sum = {1'b0, score_q};
    case (gm)
      GM_INIT: begin
        div_d   = '0;
        dist_d  = '0;
        speed_d = SPEED_INIT;
        score_d = '0;
        ramp_d  = '0;
        valid_d = '0;
        for (int k = 0; k < NUM_OBS; k++) begin
          xl_d[k] = '0;
          xr_d[k] = '0;
          yt_d[k] = '0;
          yb_d[k] = '0;
        end
      end
      GM_PLAY: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          // Every decision below reads pre-tick state, so a slot freed now
          // cannot be refilled until the next tick.
          for (int k = 0; k < NUM_OBS; k++) begin
            if (valid_q[k]) begin
              if (xr_q[k] <= spd_x) begin
                valid_d[k] = 1'b0;
                xl_d[k]    = '0;
                xr_d[k]    = '0;
                yt_d[k]    = '0;
                yb_d[k]    = '0;
                n_freed    = n_freed + CNT_W'(1);
              end else begin
                xr_d[k] = xr_q[k] - spd_x;
                xl_d[k] = (xl_q[k] > spd_x) ? xl_q[k] - spd_x : '0;
              end
            end else if (spawn_go && (free_idx == IDX_W'(k))) begin
              valid_d[k] = 1'b1;
              xl_d[k]    = SPAWN_XL;
              xr_d[k]    = SPAWN_XR;
              yt_d[k]    = spawn_top;
              yb_d[k]    = spawn_bot;
            end
          end
          score_sum = {1'b0, score_q} + 17'(n_freed);
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          if (dist_sum >= GAP) begin
            dist_d = free_found ? (dist_sum - GAP) : GAP;
          end else begin
            dist_d = dist_sum;
          end
          if (spawn_go) begin
            if (ramp_q == RAMP_LAST) begin
              ramp_d  = '0;
              speed_d = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 4'd1;
            end else begin
              ramp_d = ramp_q + RC_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      dist_q  <= '0;
      speed_q <= SPEED_INIT;
      score_q <= '0;
      ramp_q  <= '0;
      valid_q <= '0;
      for (int k = 0; k < NUM_OBS; k++) begin
        xl_q[k] <= '0;
        xr_q[k] <= '0;
        yt_q[k] <= '0;
        yb_q[k] <= '0;
      end
    end else begin
      div_q   <= div_d;
      dist_q  <= dist_d;
      speed_q <= speed_d;
      score_q <= score_d;
      ramp_q  <= ramp_d;
      valid_q <= valid_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      yt_q    <= yt_d;
      yb_q    <= yb_d;
    end
  end

  always_comb begin
    obstacle_x = '0;
    obstacle_y = '0;
    for (int k = 0; k < NUM_OBS; k++) begin
      obstacle_x[k*X_SLOT_W       +: X_W] = xl_q[k];
      obstacle_x[k*X_SLOT_W + X_W +: X_W] = xr_q[k];
      obstacle_y[k*Y_SLOT_W       +: Y_W] = yt_q[k];
      obstacle_y[k*Y_SLOT_W + Y_W +: Y_W] = yb_q[k];
    end
  end

  assign speed = speed_q;
  assign score = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: three instances with a fast scroll
// divider exercise scrolling, pausing, slot exhaustion, speed ramp and reset.
module tb_obstacle_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  gm1, gm2, gm3;

  logic [199:0]  ox1;
  logic [179:0]  oy1;
  logic [3:0]    sp1;
  logic [15:0]   sc1;
  logic [199:0]  ox2;
  logic [179:0]  oy2;
  logic [3:0]    sp2;
  logic [15:0]   sc2;
  logic [1279:0] ox3;
  logic [1151:0] oy3;
  logic [3:0]    sp3;
  logic [15:0]   sc3;

  int total = 0;
  int bad   = 0;

  obstacle_scheduler #(.SCROLL_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .gamemode(gm1),
    .obstacle_x(ox1), .obstacle_y(oy1), .speed(sp1), .score(sc1)
  );

  obstacle_scheduler #(.SCROLL_DIV(4), .SPAWN_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .gamemode(gm2),
    .obstacle_x(ox2), .obstacle_y(oy2), .speed(sp2), .score(sc2)
  );

  obstacle_scheduler #(.SCROLL_DIV(4), .SPAWN_GAP(2), .NUM_OBS(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .gamemode(gm3),
    .obstacle_x(ox3), .obstacle_y(oy3), .speed(sp3), .score(sc3)
  );

  task automatic chk(input string tag, input logic [1279:0] obs, input logic [1279:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  // {y_bottom, y_top} for a spawn made with LFSR state l.
  function automatic logic [17:0] exp_y(input logic [15:0] l);
    int hh;
    hh = 40 + int'(l[6:1]);
    return l[0] ? {9'(360), 9'(360 - hh)} : {9'(120 + hh), 9'(120)};
  endfunction

  localparam logic [19:0] X_SPAWN = {10'd639, 10'd600};

  initial begin
    rst_n = 1'b0;
    gm1 = 2'b00;
    gm2 = 2'b00;
    gm3 = 2'b00;
    #12;
    chk("reset_x", ox1, '0);
    chk("reset_y", oy1, '0);
    chk("reset_speed", sp1, 4'd2);
    chk("reset_score", sc1, 16'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Single-slot life cycle with the real spawn gap.
    gm1 = 2'b01;
    step(319);
    chk("t79_slot0_empty", ox1[0 +: 20], '0);
    step(1);
    chk("t80_slot0_x", ox1[0 +: 20], X_SPAWN);
    chk("t80_slot0_y", oy1[0 +: 18], exp_y(lfsr_after(79)));
    step(4);
    chk("t81_slot0_x", ox1[0 +: 20], {10'd637, 10'd598});
    step(1192);
    chk("m299_slot0_x", ox1[0 +: 20], {10'd41, 10'd2});
    step(4);
    chk("m300_clamp_x", ox1[0 +: 20], {10'd39, 10'd0});
    step(76);
    chk("m319_slot0_x", ox1[0 +: 20], {10'd1, 10'd0});
    chk("m319_score", sc1, 16'd0);
    step(4);
    chk("t400_slot0_freed", ox1[0 +: 20], '0);
    chk("t400_score", sc1, 16'd1);
    chk("t400_slot1_x", ox1[20 +: 20], {10'd159, 10'd120});
    chk("t400_slot4_x", ox1[80 +: 20], X_SPAWN);
    chk("t400_slot4_y", oy1[72 +: 18], exp_y(lfsr_after(399)));
    chk("t400_speed", sp1, 4'd2);

    // Pause with the divider mid-count, then resume.
    step(2);
    gm1 = 2'b10;
    step(100);
    chk("pause_slot1_x", ox1[20 +: 20], {10'd159, 10'd120});
    chk("pause_score", sc1, 16'd1);
    chk("pause_div", dut1.div_q, 2'd2);
    gm1 = 2'b01;
    step(1);
    chk("resume_1clk_x", ox1[20 +: 20], {10'd159, 10'd120});
    step(1);
    chk("resume_2clk_x", ox1[20 +: 20], {10'd157, 10'd118});

    // Tiny spawn gap: fill all ten slots, hold, then refill.
    gm2 = 2'b01;
    step(4);
    chk("g2_t1_slot0_x", ox2[0 +: 20], X_SPAWN);
    chk("g2_t1_slot0_y", oy2[0 +: 18], exp_y(16'hACE1));
    chk("g2_t1_slot1_empty", ox2[20 +: 20], '0);
    step(28);
    chk("g2_t8_speed", sp2, 4'd3);
    chk("g2_t8_slot7_x", ox2[140 +: 20], X_SPAWN);
    step(8);
    chk("g2_t10_slot9_x", ox2[180 +: 20], X_SPAWN);
    step(4);
    chk("g2_t11_dist_held", dut2.dist_q, 10'd2);
    step(820);
    chk("g2_t216_slot0_x", ox2[0 +: 20], {10'd1, 10'd0});
    step(4);
    chk("g2_t217_slot0_freed", ox2[0 +: 20], '0);
    chk("g2_t217_slot1_freed", ox2[20 +: 20], '0);
    chk("g2_t217_score", sc2, 16'd2);
    chk("g2_t217_dist_held", dut2.dist_q, 10'd2);
    step(4);
    chk("g2_t218_refill_x", ox2[0 +: 20], X_SPAWN);
    chk("g2_t218_refill_y", oy2[0 +: 18], exp_y(lfsr_after(217)));
    chk("g2_t218_slot2_freed", ox2[40 +: 20], '0);
    chk("g2_t218_score", sc2, 16'd3);

    // Speed ramp to saturation, multi-free tick, then end -> init clear.
    gm3 = 2'b01;
    step(28);
    chk("g3_t7_speed", sp3, 4'd2);
    step(4);
    chk("g3_t8_speed", sp3, 4'd3);
    step(156);
    chk("g3_t47_speed", sp3, 4'd7);
    step(4);
    chk("g3_t48_speed", sp3, 4'd8);
    step(32);
    chk("g3_t56_speed_sat", sp3, 4'd8);
    step(180);
    chk("g3_t101_score", sc3, 16'd0);
    step(4);
    chk("g3_t102_score_multi", sc3, 16'd4);
    chk("g3_t102_slot4_x", ox3[80 +: 20], {10'd1, 10'd0});
    gm3 = 2'b11;
    step(3);
    chk("g3_end_hold_score", sc3, 16'd4);
    gm3 = 2'b00;
    step(1);
    chk("g3_clear_x", ox3, '0);
    chk("g3_clear_y", oy3, '0);
    chk("g3_clear_speed", sp3, 4'd2);
    chk("g3_clear_score", sc3, 16'd0);

    // Asynchronous reset in the middle of a clock period.
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x1", ox1, '0);
    chk("arst_y1", oy1, '0);
    chk("arst_speed2", sp2, 4'd2);
    chk("arst_score1", sc1, 16'd0);
    chk("arst_x2", ox2, '0);
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
